// File: rtl/layer_compositor_pkg.sv
// -----------------------------------------------------------------------------
// layer_compositor_pkg
// Shared colour definitions for the layer compositor and its pixel sources.
//   COLOR_WIDTH : bits per pixel colour (RGB332)
//   color_t     : one pixel colour
//   COLOR_NONE  : transparency key; a layer showing it never wins
//   COLOR_*     : named colours used by the canvas/cursor sources
//   layer_eligible() : per-layer eligibility predicate used at acceptance
// -----------------------------------------------------------------------------
package layer_compositor_pkg;

  localparam int COLOR_WIDTH = 8;

  typedef logic [COLOR_WIDTH-1:0] color_t;

  localparam color_t COLOR_BLACK = 8'h00;
  localparam color_t COLOR_BLUE  = 8'h03;
  localparam color_t COLOR_GREEN = 8'h1C;
  localparam color_t COLOR_RED   = 8'hE0;
  localparam color_t COLOR_WHITE = 8'hFF;
  // Magenta is reserved as the "no pixel here" key.
  localparam color_t COLOR_NONE  = 8'hE3;

  // A layer above the background competes only if it covers the pixel, is
  // enabled, is not in the dark half of its blink cycle and is not transparent.
  function automatic logic layer_eligible(
    input logic   visible,
    input logic   enable,
    input logic   blink,
    input logic   phase,
    input color_t color
  );
    return visible && enable && (!blink || phase) && (color != COLOR_NONE);
  endfunction

endpackage

// File: rtl/layer_compositor_blink_timer.sv
// -----------------------------------------------------------------------------
// blink_timer
// Counts start-of-frame ticks and toggles a blink phase every BLINK_FRAMES
// ticks. Phase 1 means blinking layers are shown.
//   clk   : system clock
//   reset : asynchronous active-high; counter 0, phase 1
//   tick  : one accepted start-of-frame beat
//   phase : current blink phase
// -----------------------------------------------------------------------------
module blink_timer
  import layer_compositor_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic phase
);

  // A single-frame phase still needs a one-bit counter that simply stays 0.
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_phase <= 1'b1;
    end else if (tick) begin
      if (r_count == CNT_LAST) begin
        r_count <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/layer_compositor.sv
// -----------------------------------------------------------------------------
// layer_compositor
// Two-stage pipelined priority compositor. Each accepted beat carries one
// colour per layer plus coverage flags; the highest-index eligible layer wins,
// falling back to layer 0 (background) when nothing above it qualifies.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready is combinational from
//                         out_ready)
//   in_sof              : first pixel of a frame, drives the blink timer
//   layer_color         : NUM_LAYERS packed colours, layer i at bits
//                         [i*COLOR_WIDTH +: COLOR_WIDTH]
//   layer_visible       : per-layer coverage, bit 0 ignored
//   cfg_we/cfg_layer/cfg_enable/cfg_blink : per-layer enable/blink write port
//   out_valid/out_ready : output handshake
//   render_color        : winning colour
//   render_layer        : winning layer index
// -----------------------------------------------------------------------------
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS   = 5,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_sof,
  input  logic [NUM_LAYERS*COLOR_WIDTH-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]             layer_visible,
  input  logic                              cfg_we,
  input  logic [$clog2(NUM_LAYERS)-1:0]     cfg_layer,
  input  logic                              cfg_enable,
  input  logic                              cfg_blink,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [COLOR_WIDTH-1:0]            render_color,
  output logic [$clog2(NUM_LAYERS)-1:0]     render_layer
);

  localparam int LAYER_W = $clog2(NUM_LAYERS);
  localparam int COLOR_W = NUM_LAYERS * COLOR_WIDTH;

  // ---------------------------------------------------------------------------
  // Handshake and stall control
  // ---------------------------------------------------------------------------
  logic w_s2_load;
  logic w_s1_load;
  logic w_accept;
  logic w_tick;
  logic w_phase;

  logic r_s1_valid;
  logic r_s2_valid;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign w_accept  = in_valid && w_s1_load;
  assign w_tick    = w_accept && in_sof;
  assign in_ready  = w_s1_load;

  // ---------------------------------------------------------------------------
  // Per-layer configuration. Each layer decodes its own address, so an
  // out-of-range cfg_layer matches no layer and the write falls away.
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] w_en;
  logic [NUM_LAYERS-1:0] w_blk;

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_cfg
      logic r_en;
      logic r_blk;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_en  <= 1'b1;
          r_blk <= 1'b0;
        end else if (cfg_we && (cfg_layer == LAYER_W'(gi))) begin
          r_en  <= cfg_enable;
          r_blk <= cfg_blink;
        end
      end

      assign w_en[gi]  = r_en;
      assign w_blk[gi] = r_blk;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Blink timer, advanced only by accepted start-of-frame beats
  // ---------------------------------------------------------------------------
  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick),
    .phase(w_phase)
  );

  // ---------------------------------------------------------------------------
  // Eligibility mask, evaluated against configuration and phase as they stand
  // before the acceptance edge. Layer 0 always qualifies as the fallback, so
  // it carries no mask bit.
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:1] w_elig;

  generate
    for (genvar gi = 1; gi < NUM_LAYERS; gi++) begin : g_elig
      assign w_elig[gi] = layer_eligible(
        layer_visible[gi],
        w_en[gi],
        w_blk[gi],
        w_phase,
        layer_color[gi*COLOR_WIDTH +: COLOR_WIDTH]
      );
    end
  endgenerate

  // Layer 0's coverage and config bits exist but never influence the result.
  logic w_unused_layer0;
  assign w_unused_layer0 = layer_visible[0] ^ w_en[0] ^ w_blk[0];

  // ---------------------------------------------------------------------------
  // Stage S1: colours and eligibility mask
  // ---------------------------------------------------------------------------
  logic [COLOR_W-1:0]    r_s1_color;
  logic [NUM_LAYERS-1:1] r_s1_elig;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_color <= '0;
      r_s1_elig  <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_color <= layer_color;
        r_s1_elig  <= w_elig;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Priority select: walk upward so the highest eligible index overwrites.
  // ---------------------------------------------------------------------------
  color_t             w_sel_color;
  logic [LAYER_W-1:0] w_sel_layer;

  always_comb begin
    w_sel_color = r_s1_color[COLOR_WIDTH-1:0];
    w_sel_layer = '0;
    for (int i = 1; i < NUM_LAYERS; i++) begin
      if (r_s1_elig[i]) begin
        w_sel_color = r_s1_color[i*COLOR_WIDTH +: COLOR_WIDTH];
        w_sel_layer = LAYER_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage S2: output register. Data only moves when a real beat arrives, so
  // the outputs stay frozen under back-pressure and after the last beat.
  // ---------------------------------------------------------------------------
  color_t             r_s2_color;
  logic [LAYER_W-1:0] r_s2_layer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_color <= '0;
      r_s2_layer <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_color <= w_sel_color;
        r_s2_layer <= w_sel_layer;
      end
    end
  end

  assign out_valid    = r_s2_valid;
  assign render_color = r_s2_color;
  assign render_layer = r_s2_layer;

endmodule

// File: tb/tb_layer_compositor.sv
// -----------------------------------------------------------------------------
// tb_layer_compositor
// Directed bench for layer_compositor with NUM_LAYERS=5, BLINK_FRAMES=2.
// -----------------------------------------------------------------------------
module tb_layer_compositor;
  import layer_compositor_pkg::*;

  localparam int NL = 5;
  localparam int LW = 3;
  localparam int W  = NL * COLOR_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic [W-1:0]  layer_color;
  logic [NL-1:0] layer_visible;
  logic          cfg_we;
  logic [LW-1:0] cfg_layer;
  logic          cfg_enable;
  logic          cfg_blink;
  logic          out_valid;
  logic          out_ready;
  color_t        render_color;
  logic [LW-1:0] render_layer;

  always #5 clk = ~clk;

  layer_compositor #(
    .NUM_LAYERS  (NL),
    .BLINK_FRAMES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sof       (in_sof),
    .layer_color  (layer_color),
    .layer_visible(layer_visible),
    .cfg_we       (cfg_we),
    .cfg_layer    (cfg_layer),
    .cfg_enable   (cfg_enable),
    .cfg_blink    (cfg_blink),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .render_color (render_color),
    .render_layer (render_layer)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Delivered beats, captured mid-cycle ahead of the edge that completes them.
  color_t        q_color[$];
  logic [LW-1:0] q_layer[$];
  int            n_delivered = 0;

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      q_color.push_back(render_color);
      q_layer.push_back(render_layer);
      $display("beat %0d delivered: color=0x%02h layer=%0d", n_delivered, render_color, render_layer);
      n_delivered++;
    end
  end

  function automatic logic [W-1:0] pack5(input color_t c0, input color_t c1, input color_t c2,
                                         input color_t c3, input color_t c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  // Present one beat and return 1 time unit after the edge that accepts it.
  task automatic drive_beat(input logic [W-1:0] colors, input logic [NL-1:0] vis, input logic sof);
    int n;
    layer_color   = colors;
    layer_visible = vis;
    in_sof        = sof;
    in_valid      = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic cfg_write(input logic [LW-1:0] l, input logic en, input logic bk);
    cfg_layer  = l;
    cfg_enable = en;
    cfg_blink  = bk;
    cfg_we     = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic expect_out(input string tag, input color_t exp_c, input logic [LW-1:0] exp_l);
    int n;
    color_t        c;
    logic [LW-1:0] l;
    n = 0;
    while (q_color.size() == 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q_color.size() == 0) begin
      check_eq({tag, "_delivered"}, q_color.size(), 1);
    end else begin
      c = q_color.pop_front();
      l = q_layer.pop_front();
      check_eq({tag, "_color"}, c, exp_c);
      check_eq({tag, "_layer"}, l, exp_l);
    end
  endtask

  logic [W-1:0] all_on;
  logic [W-1:0] top_none;
  logic [W-1:0] only_bg;
  int           blink_exp [6] = '{4, 4, 3, 3, 4, 4};

  initial begin
    all_on   = pack5(COLOR_NONE, COLOR_BLUE, COLOR_GREEN, COLOR_RED, COLOR_BLACK);
    top_none = pack5(COLOR_NONE, COLOR_BLUE, COLOR_GREEN, COLOR_RED, COLOR_NONE);
    only_bg  = pack5(COLOR_WHITE, COLOR_NONE, COLOR_NONE, COLOR_NONE, COLOR_NONE);

    reset         = 1'b1;
    in_valid      = 1'b0;
    in_sof        = 1'b0;
    layer_color   = '0;
    layer_visible = '0;
    cfg_we        = 1'b0;
    cfg_layer     = '0;
    cfg_enable    = 1'b0;
    cfg_blink     = 1'b0;
    out_ready     = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_color", render_color, 0);
    check_eq("rst_layer", render_layer, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_in_ready", in_ready, 1);

    // Full stack, with latency observed directly on out_valid
    layer_color   = all_on;
    layer_visible = '1;
    in_valid      = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("lat_cycle1_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("lat_cycle2_valid", out_valid, 1);
    check_eq("lat_cycle2_color", render_color, COLOR_BLACK);
    check_eq("lat_cycle2_layer", render_layer, 4);
    expect_out("full_stack", COLOR_BLACK, 4);

    // Transparent top layer, then background fallbacks
    drive_beat(top_none, '1, 1'b0);
    expect_out("top_none", COLOR_RED, 3);
    drive_beat(all_on, 5'b00001, 1'b0);
    expect_out("bg_none", COLOR_NONE, 0);
    drive_beat(only_bg, '1, 1'b0);
    expect_out("bg_white", COLOR_WHITE, 0);

    // Config write coinciding with acceptance only affects the next beat
    cfg_layer  = 3'd4;
    cfg_enable = 1'b0;
    cfg_blink  = 1'b0;
    cfg_we     = 1'b1;
    drive_beat(all_on, '1, 1'b0);
    drive_beat(all_on, '1, 1'b0);
    expect_out("cfg_same_cycle", COLOR_BLACK, 4);
    expect_out("cfg_next_beat", COLOR_RED, 3);
    cfg_write(3'd4, 1'b1, 1'b0);
    cfg_write(3'd7, 1'b0, 1'b0);
    drive_beat(all_on, '1, 1'b0);
    expect_out("cfg_out_of_range", COLOR_BLACK, 4);
    cfg_write(3'd0, 1'b0, 1'b0);
    drive_beat(only_bg, '1, 1'b0);
    expect_out("cfg_layer0", COLOR_WHITE, 0);
    cfg_write(3'd0, 1'b1, 1'b0);

    // Blink: shown on beats 1-2, hidden on 3-4, shown on 5-6
    cfg_write(3'd4, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      drive_beat(all_on, '1, 1'b1);
      expect_out($sformatf("blink%0d", k + 1), (blink_exp[k] == 4) ? COLOR_BLACK : COLOR_RED,
                 LW'(blink_exp[k]));
      if (k == 0) begin
        // in_sof without in_valid must not advance the timer
        in_sof = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_sof = 1'b0;
      end
    end
    cfg_write(3'd4, 1'b1, 1'b0);

    // Back-pressure stream of 8 counting beats
    repeat (2) @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          drive_beat(pack5(color_t'(8'h10 + k), COLOR_BLUE, COLOR_GREEN, COLOR_RED, COLOR_BLACK),
                     5'b00001, 1'b0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check_eq($sformatf("stall%0d_in_ready", s), in_ready, 0);
          check_eq($sformatf("stall%0d_out_valid", s), out_valid, 1);
          check_eq($sformatf("stall%0d_color", s), render_color, 8'h11);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 8; k++) begin
      expect_out($sformatf("stream%0d", k), color_t'(8'h10 + k), 0);
    end
    repeat (5) @(posedge clk);
    #1;
    check_eq("stream_no_extra", q_color.size(), 0);

    // Reset with two beats in flight; blink phase was left at 0 above
    drive_beat(all_on, '1, 1'b0);
    drive_beat(all_on, '1, 1'b0);
    check_eq("inflight_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rel_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_discarded", q_color.size(), 0);
    cfg_write(3'd4, 1'b1, 1'b1);
    drive_beat(all_on, '1, 1'b0);
    expect_out("rst_phase1", COLOR_BLACK, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised, pipelined successor to the fixed five-input compositor. Merges NUM_LAYERS colour layers per pixel by fixed priority, highest index on top. Adds per-layer enable/blink configuration, a frame-driven blink timer, and a valid/ready stream interface. Sits between the camera/canvas/cursor pixel sources and the VGA driver.

## Interface
- NUM_LAYERS, 5: layer count including background layer 0; legal range 2..16.
- BLINK_FRAMES, 30: accepted start-of-frame beats per blink phase; must be at least 1.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_sof  in  1  beat is the first pixel of a frame.
- layer_color  in  NUM_LAYERS x COLOR_WIDTH  per-layer pixel colour; index 0 is the camera/background.
- layer_visible  in  NUM_LAYERS  per-pixel coverage flag; bit 0 is ignored.
- cfg_we  in  1  configuration write strobe.
- cfg_layer  in  $clog2(NUM_LAYERS)  target layer for the write.
- cfg_enable  in  1  new enable bit for the target layer.
- cfg_blink  in  1  new blink bit for the target layer.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- render_color  out  COLOR_WIDTH  composited colour.
- render_layer  out  $clog2(NUM_LAYERS)  index of the winning layer.

## Operation
- Handshakes:
  - A beat is accepted when in_valid && in_ready.
  - A beat is delivered when out_valid && out_ready.
- Per-layer config registers en[i] and blk[i]:
  - Reset values: en = all 1, blk = all 0.
  - On cfg_we, en[cfg_layer] <= cfg_enable and blk[cfg_layer] <= cfg_blink.
  - A write with cfg_layer >= NUM_LAYERS is ignored.
  - Writes to layer 0 are stored but have no effect.
- Blink timer:
  - State is a counter (0..BLINK_FRAMES-1) and a phase bit. Reset values: counter 0, phase 1.
  - On an accepted beat with in_sof, the counter increments.
  - On wrap from BLINK_FRAMES-1 to 0, phase toggles.
  - in_sof on a non-accepted cycle has no effect.
- Layer i>0 is eligible when all of the following hold:
  - layer_visible[i] is 1;
  - en[i] is 1;
  - blk[i] is 0, or phase is 1;
  - layer_color[i] != COLOR_NONE.
- Winner: the highest eligible index. If no layer i>0 is eligible, layer 0 wins unconditionally, even if its colour is COLOR_NONE.
- Outputs: render_color is the winner's colour; render_layer is the winner's index.

## Timing
- Stage S1 registers the input colours and an eligibility mask computed at acceptance.
- Stage S2 registers the priority-select result and drives render_color and render_layer.
- Latency: an accepted beat appears on out_valid 2 cycles later if out_ready stays 1.
- Throughput: 1 beat per cycle.
- Stall rules:
  - S2 loads when !s2_valid || out_ready.
  - S1 loads when !s1_valid || (S2 loads).
  - in_ready = !s1_valid || (S2 loads). This is combinational from out_ready.
- Outputs hold stable while out_valid && !out_ready. No beat is dropped or duplicated.
- Config and phase sampling:
  - The eligibility mask uses en, blk and phase as registered before the acceptance edge.
  - A config write on the same cycle as an acceptance affects only later beats.
  - Phase sampling: the phase toggle from a wrapping in_sof beat applies to the following beat, not to that beat itself.
- Reset values:
  - out_valid 0, render_color 0, render_layer 0, S1/S2 valid 0.
  - in_ready is 1 during and after reset.
- Reset mid-stream discards all in-flight beats immediately.

## Structure
- Add typedef color_t (logic [COLOR_WIDTH-1:0]) to the shared common.sv package.
- COLOR_WIDTH, COLOR_NONE and the named colours remain in that package.
- Sub-module blink_timer:
  - Parameter: BLINK_FRAMES.
  - Ports: clk, reset, tick (accepted in_sof), phase.
  - Instantiated once.
- The priority select is a for-loop over layers with the highest index last. Widths come from $clog2(NUM_LAYERS).

## Test plan
- All layers visible and enabled; colours L0..L4 = NONE, BLUE, GREEN, RED, BLACK; out_ready=1 -> render_color BLACK, render_layer 4, exactly 2 cycles after acceptance.
- Same inputs with layer_color[4] = COLOR_NONE -> RED/3. With only layer 0 remaining (others invisible, L0 = NONE) -> render_color COLOR_NONE, render_layer 0.
- Write cfg_layer=4, cfg_enable=0 on the same cycle as an accepted beat -> that beat returns BLACK/4 and the next beat returns RED/3. A write with cfg_layer=7 leaves all outputs unchanged.
- BLINK_FRAMES=2, blk[4]=1: send sof beats -> L4 shown on beats 1–2, hidden (RED/3) on beats 3–4, shown again on beats 5–6.
- Stream 8 beats with a counting colour, holding out_ready=0 for 3 cycles mid-stream -> in_ready drops after 2 buffered beats, outputs hold steady, all 8 beats are delivered in order with none lost or repeated.
- Assert reset while 2 beats are in flight -> out_valid goes to 0 immediately; after release, in_ready=1 and blink phase=1.
